// File: rtl/udp_vid_rx_pkg.sv
// Shared state encoding, default frame marker and pixel byte-lane helper
// for the UDP-to-video receive path.
package udp_vid_rx_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_REC  = 2'b10
    } state_e;

    localparam logic [31:0] DEF_FRAME_HEAD = 32'hF3ED7A93;

    // Bit offset of byte slot `pos` inside a pixel of `bpp` bytes.
    function automatic int byte_ofs(input logic [1:0] pos, input int bpp, input bit msb_first);
        int lane;
        lane = msb_first ? (bpp - 1 - int'(pos)) : int'(pos);
        return 8 * lane;
    endfunction
endpackage

// File: rtl/udp_vid_rx_hdr_detect.sv
// Frame marker search: three bytes of history plus the live byte compared
// against the 32-bit marker.
module udp_hdr_detect
    import udp_vid_rx_pkg::*;
#(
    parameter logic [31:0] FRAME_HEAD = DEF_FRAME_HEAD
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       clr,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       hit
);
    logic [23:0] hist_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
        end else if (en && valid) begin
            hist_q <= {hist_q[15:0], data};
        end
    end

    assign hit = en && valid && ({hist_q, data} == FRAME_HEAD);
endmodule

// File: rtl/udp_vid_rx.sv
// UDP byte stream to video pixel stream: header search, pixel packing,
// line/frame counting and receive-timeout abort.
module udp_vid_rx
    import udp_vid_rx_pkg::*;
#(
    parameter logic [31:0] FRAME_HEAD    = DEF_FRAME_HEAD,
    parameter int          BYTES_PER_PIX = 2,
    parameter bit          MSB_FIRST     = 1'b1,
    parameter int          H_ACTIVE      = 640,
    parameter int          V_ACTIVE      = 480,
    parameter int          TIMEOUT       = 125000,
    localparam int         PIX_W         = 8 * BYTES_PER_PIX
) (
    input  logic             app_rx_clk,
    input  logic             rstn,
    input  logic             app_rx_data_valid,
    input  logic [7:0]       app_rx_data,
    output logic             vid_clk,
    output logic             vid_vs,
    output logic             vid_de,
    output logic [PIX_W-1:0] vid_data,
    output logic             vid_eol,
    output logic             vid_eof,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
    localparam logic [1:0]    B_LAST = 2'(BYTES_PER_PIX - 1);

    state_e           state_q;
    logic [1:0]       bcnt_q;
    logic [XW-1:0]    xcnt_q;
    logic [YW-1:0]    ycnt_q;
    logic [TW-1:0]    tcnt_q;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             vs_q, de_q, eol_q, eof_q, err_q;
    logic [PIX_W-1:0] data_q;
    logic [15:0]      frame_cnt_q;
    logic             hit, pix_done, x_last, y_last;

    udp_hdr_detect #(.FRAME_HEAD(FRAME_HEAD)) u_hdr (
        .clk   (app_rx_clk),
        .rstn  (rstn),
        .en    (state_q == ST_IDLE),
        .clr   (hit),
        .valid (app_rx_data_valid),
        .data  (app_rx_data),
        .hit   (hit)
    );

    always_comb begin
        pix_d = pix_q;
        pix_d[byte_ofs(bcnt_q, BYTES_PER_PIX, MSB_FIRST) +: 8] = app_rx_data;
    end

    assign pix_done = (bcnt_q == B_LAST);
    assign x_last   = (xcnt_q == X_LAST);
    assign y_last   = (ycnt_q == Y_LAST);

    always_ff @(posedge app_rx_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            bcnt_q      <= '0;
            xcnt_q      <= '0;
            ycnt_q      <= '0;
            tcnt_q      <= '0;
            pix_q       <= '0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            data_q      <= '0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            data_q <= '0;
            eol_q  <= 1'b0;
            eof_q  <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        state_q <= ST_REC;
                        vs_q    <= 1'b1;
                        bcnt_q  <= '0;
                        xcnt_q  <= '0;
                        ycnt_q  <= '0;
                        tcnt_q  <= '0;
                        pix_q   <= '0;
                    end
                end
                ST_REC: begin
                    // A byte arriving in the TIMEOUT cycle wins over the abort.
                    if (app_rx_data_valid) begin
                        tcnt_q <= '0;
                        if (pix_done) begin
                            bcnt_q <= '0;
                            pix_q  <= '0;
                            de_q   <= 1'b1;
                            data_q <= pix_d;
                            eol_q  <= x_last;
                            eof_q  <= x_last && y_last;
                            if (x_last) begin
                                xcnt_q <= '0;
                                if (y_last) begin
                                    ycnt_q      <= '0;
                                    state_q     <= ST_IDLE;
                                    frame_cnt_q <= frame_cnt_q + 16'd1;
                                end else begin
                                    ycnt_q <= ycnt_q + YW'(1);
                                end
                            end else begin
                                xcnt_q <= xcnt_q + XW'(1);
                            end
                        end else begin
                            bcnt_q <= bcnt_q + 2'd1;
                            pix_q  <= pix_d;
                        end
                    end else if (tcnt_q == T_MAX) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                        bcnt_q  <= '0;
                        xcnt_q  <= '0;
                        ycnt_q  <= '0;
                        tcnt_q  <= '0;
                        pix_q   <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vid_clk   = app_rx_clk;
    assign vid_vs    = vs_q;
    assign vid_de    = de_q;
    assign vid_data  = data_q;
    assign vid_eol   = eol_q;
    assign vid_eof   = eof_q;
    assign frame_err = err_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_udp_vid_rx.sv
// Directed bench for udp_vid_rx: a 4x2 two-byte MSB-first instance and a
// three-byte LSB-first instance share the clock and reset.
module tb_udp_vid_rx;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic valid = 1'b0, valid3 = 1'b0;
    logic [7:0] data = 8'h00, data3 = 8'h00;

    logic vclk, vs, de, eol, eof, ferr;
    logic [15:0] vdata, fcnt;
    logic vclk3, vs3, de3, eol3, eof3, ferr3;
    logic [23:0] vdata3;
    logic [15:0] fcnt3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_drive = 0;
    int hdr_end = 0;
    int first_data = 0;
    int vs_n, vs_at, de_n, err_n, err_at, both_n, dz_n, de3_n;
    logic [15:0] pix [64];
    bit eol_f [64];
    bit eof_f [64];
    int de_at [64];
    logic [23:0] pix3 [8];

    always #4 clk = ~clk;

    udp_vid_rx #(.BYTES_PER_PIX(2), .MSB_FIRST(1'b1), .H_ACTIVE(4), .V_ACTIVE(2), .TIMEOUT(10)) dut (
        .app_rx_clk(clk), .rstn(rstn), .app_rx_data_valid(valid), .app_rx_data(data),
        .vid_clk(vclk), .vid_vs(vs), .vid_de(de), .vid_data(vdata), .vid_eol(eol),
        .vid_eof(eof), .frame_err(ferr), .frame_cnt(fcnt));

    udp_vid_rx #(.BYTES_PER_PIX(3), .MSB_FIRST(1'b0), .H_ACTIVE(4), .V_ACTIVE(2), .TIMEOUT(10)) dut3 (
        .app_rx_clk(clk), .rstn(rstn), .app_rx_data_valid(valid3), .app_rx_data(data3),
        .vid_clk(vclk3), .vid_vs(vs3), .vid_de(de3), .vid_data(vdata3), .vid_eol(eol3),
        .vid_eof(eof3), .frame_err(ferr3), .frame_cnt(fcnt3));

    task automatic clear_log();
        vs_n = 0; vs_at = -1; de_n = 0; err_n = 0; err_at = -1;
        both_n = 0; dz_n = 0; de3_n = 0;
    endtask

    // Sample outputs on the falling edge, then drive the next cycle's inputs.
    task automatic step_both(input logic v, input logic [7:0] d, input logic v3, input logic [7:0] d3);
        @(negedge clk);
        if (vs) begin vs_n++; vs_at = cyc; end
        if (de) begin
            if (de_n < 64) begin
                pix[de_n] = vdata; eol_f[de_n] = eol; eof_f[de_n] = eof; de_at[de_n] = cyc;
            end
            de_n++;
        end
        if (vs && de) both_n++;
        if (!de && vdata != 16'h0000) dz_n++;
        if (ferr) begin err_n++; err_at = cyc; end
        if (de3) begin
            if (de3_n < 8) pix3[de3_n] = vdata3;
            de3_n++;
        end
        valid = v; data = d; valid3 = v3; data3 = d3;
        last_drive = cyc;
        cyc++;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        step_both(v, d, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send_hdr();
        step(1'b1, 8'hF3); step(1'b1, 8'hED); step(1'b1, 8'h7A); step(1'b1, 8'h93);
        hdr_end = last_drive;
    endtask

    // Header, then 16 bytes base..base+15 with `gap` idle cycles after each.
    task automatic send_frame(input logic [7:0] base, input int gap);
        send_hdr();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, base + 8'(i));
            if (i == 0) first_data = last_drive;
            idle(gap);
        end
        idle(4);
    endtask

    task automatic test_reset();
        idle(3);
        checks++; if (vs !== 1'b0 || de !== 1'b0) begin failures++; $display("FAIL reset_strobes got vs=%b de=%b exp 0 0", vs, de); end
        checks++; if (vdata !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", vdata); end
        checks++; if (eol !== 1'b0 || eof !== 1'b0 || ferr !== 1'b0) begin failures++; $display("FAIL reset_flags got eol=%b eof=%b err=%b exp 0 0 0", eol, eof, ferr); end
        checks++; if (fcnt !== 16'h0000 || fcnt3 !== 16'h0000) begin failures++; $display("FAIL reset_frame_cnt got=%h/%h exp=0000", fcnt, fcnt3); end
        checks++; if (vs3 !== 1'b0 || de3 !== 1'b0 || vdata3 !== 24'h0 || eol3 !== 1'b0 || eof3 !== 1'b0 || ferr3 !== 1'b0) begin
            failures++; $display("FAIL reset_dut3 got vs=%b de=%b data=%h exp all 0", vs3, de3, vdata3); end
        checks++; if (vclk !== clk || vclk3 !== clk) begin failures++; $display("FAIL vid_clk got=%b exp=%b", vclk, clk); end
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic test_basic_frame();
        clear_log();
        send_frame(8'h01, 0);
        checks++; if (vs_n !== 1) begin failures++; $display("FAIL basic_vs_count got=%0d exp=1", vs_n); end
        checks++; if (vs_at !== hdr_end + 1) begin failures++; $display("FAIL basic_vs_time got=%0d exp=%0d", vs_at, hdr_end + 1); end
        checks++; if (de_n !== 8) begin failures++; $display("FAIL basic_de_count got=%0d exp=8", de_n); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pix[i] !== {8'(1 + 2 * i), 8'(2 + 2 * i)} || eol_f[i] !== (i == 3 || i == 7) || eof_f[i] !== (i == 7)) begin
                failures++; $display("FAIL basic_pix%0d got=%h eol=%b eof=%b exp=%h", i, pix[i], eol_f[i], eof_f[i], {8'(1 + 2 * i), 8'(2 + 2 * i)});
            end
            checks++;
            if (de_at[i] !== first_data + 2 * i + 2) begin
                failures++; $display("FAIL basic_pix%0d_time got=%0d exp=%0d", i, de_at[i], first_data + 2 * i + 2);
            end
        end
        checks++; if (both_n !== 0 || dz_n !== 0 || err_n !== 0) begin failures++; $display("FAIL basic_side got vs_de=%0d data_nz=%0d err=%0d exp 0 0 0", both_n, dz_n, err_n); end
        checks++; if (fcnt !== 16'd1) begin failures++; $display("FAIL basic_frame_cnt got=%0d exp=1", fcnt); end
    endtask

    task automatic test_lsb_first();
        clear_log();
        step_both(1'b0, 8'h00, 1'b1, 8'hF3); step_both(1'b0, 8'h00, 1'b1, 8'hED);
        step_both(1'b0, 8'h00, 1'b1, 8'h7A); step_both(1'b0, 8'h00, 1'b1, 8'h93);
        step_both(1'b0, 8'h00, 1'b1, 8'hAA); step_both(1'b0, 8'h00, 1'b1, 8'hBB);
        step_both(1'b0, 8'h00, 1'b1, 8'hCC);
        idle(3);
        checks++; if (de3_n !== 1) begin failures++; $display("FAIL lsb_de_count got=%0d exp=1", de3_n); end
        checks++; if (pix3[0] !== 24'hCCBBAA) begin failures++; $display("FAIL lsb_pixel got=%h exp=ccbbaa", pix3[0]); end
    endtask

    task automatic test_header_near_miss();
        logic [7:0] nm [16] = '{8'h11, 8'h22, 8'hF3, 8'hED, 8'h7A, 8'h93, 8'h33, 8'h44,
                                8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        clear_log();
        step(1'b1, 8'hF3); step(1'b1, 8'hED); step(1'b1, 8'h7A); step(1'b1, 8'h00);
        send_hdr();
        for (int i = 0; i < 16; i++) step(1'b1, nm[i]);
        idle(4);
        checks++; if (vs_n !== 1) begin failures++; $display("FAIL nearmiss_vs_count got=%0d exp=1", vs_n); end
        checks++; if (vs_at !== hdr_end + 1) begin failures++; $display("FAIL nearmiss_vs_time got=%0d exp=%0d", vs_at, hdr_end + 1); end
        checks++; if (de_n !== 8) begin failures++; $display("FAIL embedded_de_count got=%0d exp=8", de_n); end
        checks++; if (pix[0] !== 16'h1122 || pix[1] !== 16'hF3ED || pix[2] !== 16'h7A93) begin
            failures++; $display("FAIL embedded_pix got=%h %h %h exp=1122 f3ed 7a93", pix[0], pix[1], pix[2]); end
        checks++; if (fcnt !== 16'd2) begin failures++; $display("FAIL nearmiss_frame_cnt got=%0d exp=2", fcnt); end
    endtask

    task automatic test_gappy();
        clear_log();
        send_frame(8'h20, 3);
        checks++; if (de_n !== 8 || err_n !== 0) begin failures++; $display("FAIL gappy_counts got de=%0d err=%0d exp 8 0", de_n, err_n); end
        for (int i = 0; i < 8; i += 7) begin
            checks++;
            if (pix[i] !== {8'(8'h20 + 2 * i), 8'(8'h21 + 2 * i)}) begin
                failures++; $display("FAIL gappy_pix%0d got=%h exp=%h", i, pix[i], {8'(8'h20 + 2 * i), 8'(8'h21 + 2 * i)});
            end
        end
        checks++; if (eof_f[7] !== 1'b1 || fcnt !== 16'd3) begin failures++; $display("FAIL gappy_end got eof=%b cnt=%0d exp 1 3", eof_f[7], fcnt); end
    endtask

    // Gaps of exactly TIMEOUT idle cycles are tolerated.
    task automatic test_timeout_boundary();
        clear_log();
        send_frame(8'h60, 10);
        checks++; if (err_n !== 0 || de_n !== 8) begin failures++; $display("FAIL tmo_edge got err=%0d de=%0d exp 0 8", err_n, de_n); end
        checks++; if (pix[5] !== 16'h6A6B || fcnt !== 16'd4) begin failures++; $display("FAIL tmo_edge_data got pix5=%h cnt=%0d exp 6a6b 4", pix[5], fcnt); end
    endtask

    task automatic test_timeout_abort();
        int last_byte;
        clear_log();
        send_hdr();
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
        last_byte = last_drive;
        idle(20);
        checks++; if (err_n !== 1) begin failures++; $display("FAIL tmo_err_count got=%0d exp=1", err_n); end
        checks++; if (err_at !== last_byte + 12) begin failures++; $display("FAIL tmo_err_time got=%0d exp=%0d", err_at, last_byte + 12); end
        checks++; if (de_n !== 2 || fcnt !== 16'd4) begin failures++; $display("FAIL tmo_partial got de=%0d cnt=%0d exp 2 4", de_n, fcnt); end
        clear_log();
        send_frame(8'h40, 0);
        checks++; if (de_n !== 8 || pix[0] !== 16'h4041 || pix[7] !== 16'h4E4F) begin
            failures++; $display("FAIL tmo_recover got de=%0d pix0=%h pix7=%h exp 8 4041 4e4f", de_n, pix[0], pix[7]); end
        checks++; if (err_n !== 0 || fcnt !== 16'd5) begin failures++; $display("FAIL tmo_recover_cnt got err=%0d cnt=%0d exp 0 5", err_n, fcnt); end
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        send_hdr();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i));
        @(negedge clk);
        checks++; if (de !== 1'b1 || vdata !== 16'h0304) begin failures++; $display("FAIL rst_pre got de=%b data=%h exp 1 0304", de, vdata); end
        valid = 1'b0;
        rstn = 1'b0;
        #1;
        checks++; if (de !== 1'b0 || vdata !== 16'h0000 || vs !== 1'b0 || eol !== 1'b0 || eof !== 1'b0) begin
            failures++; $display("FAIL rst_outputs got de=%b data=%h vs=%b exp 0 0000 0", de, vdata, vs); end
        checks++; if (fcnt !== 16'h0000 || ferr !== 1'b0) begin failures++; $display("FAIL rst_cnt got cnt=%0d err=%b exp 0 0", fcnt, ferr); end
        cyc++;
        idle(2);
        rstn = 1'b1;
        idle(15);
        checks++; if (err_n !== 0) begin failures++; $display("FAIL rst_no_err got=%0d exp=0", err_n); end
        clear_log();
        send_frame(8'h80, 0);
        checks++; if (de_n !== 8 || pix[0] !== 16'h8081 || pix[7] !== 16'h8E8F || fcnt !== 16'd1) begin
            failures++; $display("FAIL rst_recover got de=%0d pix0=%h pix7=%h cnt=%0d exp 8 8081 8e8f 1", de_n, pix[0], pix[7], fcnt); end
    endtask

    task automatic test_frame_cnt_wrap();
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        #1;
        cyc++;
        checks++; if (fcnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=ffff", fcnt); end
        clear_log();
        send_frame(8'hA0, 0);
        checks++; if (fcnt !== 16'h0000 || eof_f[7] !== 1'b1) begin failures++; $display("FAIL wrap_cnt got=%h eof=%b exp 0000 1", fcnt, eof_f[7]); end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_basic_frame();
        test_lsb_first();
        test_header_near_miss();
        test_gappy();
        test_timeout_boundary();
        test_timeout_abort();
        test_reset_mid_frame();
        test_frame_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
